// File: rtl/mario_sprite_pkg.sv
// Shared constants and types for the Mario sprite path.
// The same package is used by the sprite fetch stage, the colour palette and
// the ROM init script. That keeps the sprite geometry and the frame numbering
// in one place.
package mario_sprite_pkg;

   // Sprite geometry. Both dimensions must be powers of two.
   localparam int SPR_W      = 16;
   localparam int SPR_H      = 16;
   localparam int NUM_FRAMES = 4;

   // Palette index used as the magenta colour key.
   localparam logic [3:0] TRANSP_IDX = 4'hA;

   localparam int PAL_W   = 4;   // palette index width
   localparam int COORD_W = 10;  // screen coordinate width
   localparam int FRAME_W = 2;   // animation frame number width

   // ROM address width for a given sprite geometry and frame count.
   function automatic int rom_addr_width(input int w, input int h, input int n);
      return $clog2(w * h * n);
   endfunction

   localparam int ADDR_W = rom_addr_width(SPR_W, SPR_H, NUM_FRAMES);
   localparam int COL_W  = $clog2(SPR_W);
   localparam int ROW_W  = $clog2(SPR_H);

   // Frame layout in the sprite ROM.
   // Frame 0 is idle, the middle frames are the walk cycle, and the last frame is jump.
   typedef enum logic [FRAME_W-1:0] {
      FR_IDLE  = 2'd0,
      FR_WALK1 = 2'd1,
      FR_WALK2 = 2'd2,
      FR_JUMP  = 2'd3
   } frame_e;

endpackage

// File: rtl/mario_sprite_fetch_if.sv
// Pixel, game-state, ROM and output bundle of the Mario sprite fetch stage.
// The master side is the video timing, game logic and ROM.
// The slave side is the fetch stage itself.
interface mario_sprite_fetch_if;
   import mario_sprite_pkg::*;

   // Video timing and pixel strobe
   logic               frame_start;
   logic               pix_en;
   logic [COORD_W-1:0] DrawX;
   logic [COORD_W-1:0] DrawY;

   // Game-logic sprite state
   logic [COORD_W-1:0] MarioX;
   logic [COORD_W-1:0] MarioY;
   logic               facing_left;
   logic               walking;
   logic               jumping;

   // Sprite ROM
   logic [ADDR_W-1:0]  rom_addr;
   logic [PAL_W-1:0]   rom_data;

   // Towards the colour palette / compositor
   logic [PAL_W-1:0]   data_out;
   logic               sprite_on;
   logic               out_valid;
   logic [FRAME_W-1:0] anim_frame;

   modport master (
      output frame_start, pix_en, DrawX, DrawY,
      output MarioX, MarioY, facing_left, walking, jumping,
      output rom_data,
      input  rom_addr, data_out, sprite_on, out_valid, anim_frame
   );

   modport slave (
      input  frame_start, pix_en, DrawX, DrawY,
      input  MarioX, MarioY, facing_left, walking, jumping,
      input  rom_data,
      output rom_addr, data_out, sprite_on, out_valid, anim_frame
   );

endinterface

// File: rtl/mario_anim_ctrl.sv
// Mario animation controller.
// It keeps the walk-cycle divider and phase, and once per video frame it latches
// the ROM frame for the next picture. Jump has priority over walk.
// The latched frame uses the phase from before that frame_start's update.
module mario_anim_ctrl
   import mario_sprite_pkg::*;
#(
   parameter int ANIM_DIV = 6
) (
   input  logic   Clk,
   input  logic   Reset,
   input  logic   frame_start,
   input  logic   walking,
   input  logic   jumping,
   output frame_e anim_frame
);

   localparam int          DIV_W     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);
   localparam frame_e      WALK_LAST = frame_e'(NUM_FRAMES - 2);
   localparam frame_e      JUMP_FR   = frame_e'(NUM_FRAMES - 1);

   logic [DIV_W-1:0] div_q;
   frame_e           phase_q;

   // Frame selection and walk-phase advance, both evaluated on frame_start
   always_ff @(posedge Clk) begin
      // NOTE: non-blocking assignments here, so anim_frame samples phase_q before this edge's update.
      if (Reset) begin
         div_q      <= '0;
         phase_q    <= FR_WALK1;
         anim_frame <= FR_IDLE;
      end else if (frame_start) begin
         if (jumping)
            anim_frame <= JUMP_FR;
         else if (walking)
            anim_frame <= phase_q;
         else
            anim_frame <= FR_IDLE;

         if (!walking) begin
            // Every walk starts on the first walk frame.
            div_q   <= '0;
            phase_q <= FR_WALK1;
         end else if (!jumping) begin
            if (div_q == DIV_LAST) begin
               div_q   <= '0;
               phase_q <= (phase_q == WALK_LAST) ? FR_WALK1 : frame_e'(phase_q + 1'b1);
            end else begin
               div_q <= div_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mario_sprite_fetch.sv
// Mario sprite fetch stage. It sits just upstream of the colour palette.
// Stage 0 runs the box hit test and builds the ROM address.
// Stage 1 registers rom_addr, and stage 2 is the synchronous ROM read.
// Stage 3 registers the palette index and the sprite_on flag.
// Latency is a fixed 3 Clk, and one pixel is accepted per Clk.
// Position, facing and frame are latched on frame_start, so the sprite never tears mid-frame.
module mario_sprite_fetch
   import mario_sprite_pkg::*;
#(
   parameter int ANIM_DIV = 6
) (
   input  logic                 Clk,
   input  logic                 Reset,
   mario_sprite_fetch_if.slave  bus
);

   localparam logic [COORD_W:0] SPR_W_EXT = (COORD_W + 1)'(SPR_W);
   localparam logic [COORD_W:0] SPR_H_EXT = (COORD_W + 1)'(SPR_H);

   // Per-frame latched sprite state
   logic [COORD_W-1:0] x_q;
   logic [COORD_W-1:0] y_q;
   logic               facing_q;
   frame_e             frame_q;

   // Stage 0 (combinational)
   logic [COORD_W:0]   draw_x_ext, draw_y_ext;
   logic [COORD_W:0]   spr_x_ext, spr_y_ext;
   logic               hit_s0;
   logic [COL_W-1:0]   col_raw, col_s0;
   logic [ROW_W-1:0]   row_s0;
   logic [ADDR_W-1:0]  addr_s0;

   // Pipeline valid / hit tags
   logic               pix_en_d1, hit_d1;
   logic               pix_en_d2, hit_d2;

   mario_anim_ctrl #(
      .ANIM_DIV    (ANIM_DIV)
   ) u_anim_ctrl (
      .Clk         (Clk),
      .Reset       (Reset),
      .frame_start (bus.frame_start),
      .walking     (bus.walking),
      .jumping     (bus.jumping),
      .anim_frame  (frame_q)
   );

   assign bus.anim_frame = frame_q;

   // Latch the sprite position and facing once per video frame.
   // Reset parks the sprite off-screen until the next frame_start.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         x_q      <= '1;
         y_q      <= '1;
         facing_q <= 1'b0;
      end else if (bus.frame_start) begin
         x_q      <= bus.MarioX;
         y_q      <= bus.MarioY;
         facing_q <= bus.facing_left;
      end
   end

   // Stage 0: hit test in 11-bit arithmetic so the box clips at the screen edge instead of wrapping.
   // It also forms the mirrored ROM address.
   always_comb begin
      // NOTE: every signal gets a value before any condition, so no latch is inferred.
      draw_x_ext = {1'b0, bus.DrawX};
      draw_y_ext = {1'b0, bus.DrawY};
      spr_x_ext  = {1'b0, x_q};
      spr_y_ext  = {1'b0, y_q};

      hit_s0 = bus.pix_en
             && (draw_x_ext >= spr_x_ext) && (draw_x_ext < spr_x_ext + SPR_W_EXT)
             && (draw_y_ext >= spr_y_ext) && (draw_y_ext < spr_y_ext + SPR_H_EXT);

      col_raw = COL_W'(bus.DrawX - x_q);
      row_s0  = ROW_W'(bus.DrawY - y_q);
      col_s0  = facing_q ? (COL_W'(SPR_W - 1) - col_raw) : col_raw;

      addr_s0 = ADDR_W'(frame_q) * ADDR_W'(SPR_W * SPR_H)
              + ADDR_W'(row_s0)  * ADDR_W'(SPR_W)
              + ADDR_W'(col_s0);
   end

   // Stage 1: register the ROM address on a hit and hold it otherwise.
   // Tag the pixel as valid and as a hit.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         bus.rom_addr <= '0;
         pix_en_d1    <= 1'b0;
         hit_d1       <= 1'b0;
      end else begin
         pix_en_d1 <= bus.pix_en;
         hit_d1    <= hit_s0;
         if (hit_s0)
            bus.rom_addr <= addr_s0;
      end
   end

   // Stage 2: the ROM is reading; carry the tags alongside.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pix_en_d2 <= 1'b0;
         hit_d2    <= 1'b0;
      end else begin
         pix_en_d2 <= pix_en_d1;
         hit_d2    <= hit_d1;
      end
   end

   // Stage 3: output register. Outside the box the index is 0.
   // The colour key is drawn as not-on. data_out holds between pixels, while sprite_on drops.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         bus.data_out  <= '0;
         bus.sprite_on <= 1'b0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= pix_en_d2;
         if (pix_en_d2) begin
            bus.data_out  <= hit_d2 ? bus.rom_data : '0;
            bus.sprite_on <= hit_d2 && (bus.rom_data != TRANSP_IDX);
         end else begin
            bus.sprite_on <= 1'b0;
         end
      end
   end

endmodule

// File: doc/mario_sprite_fetch.md
Name: mario_sprite_fetch

Overview:
- Pixel-pipeline stage directly upstream of the Mario colour palette.
- For each VGA pixel strobe, decides whether (DrawX, DrawY) falls inside the Mario sprite box and generates the on-chip sprite ROM address. It selects the animation frame and horizontal mirroring, then delivers the 4-bit palette index plus a sprite_on flag, aligned for the palette/compositor.
- Sprite state is latched once per frame so motion never tears mid-frame.

Parameters:
- SPR_W, 16: sprite width in pixels (power of 2).
- SPR_H, 16: sprite height in pixels (power of 2).
- NUM_FRAMES, 4: frames in ROM. 0 = idle, 1..NUM_FRAMES-2 = walk cycle, NUM_FRAMES-1 = jump.
- ANIM_DIV, 6: video frames per walk-phase advance.
- TRANSP_IDX, 4'hA: palette index treated as transparent (magenta key).
- ADDR_W, 10: ROM address width, equal to clog2(SPR_W*SPR_H*NUM_FRAMES).

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- pix_en  in  1  pixel strobe; DrawX/DrawY valid this cycle
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- MarioX  in  10  sprite top-left column (game logic)
- MarioY  in  10  sprite top-left row
- facing_left  in  1  mirror sprite horizontally
- walking  in  1  walk animation request
- jumping  in  1  jump pose request (priority over walking)
- rom_addr  out  ADDR_W  sprite ROM address, registered
- rom_data  in  4  ROM palette index; synchronous ROM, valid 1 Clk after rom_addr
- data_out  out  4  palette index to colour palette
- sprite_on  out  1  pixel is opaque sprite pixel
- out_valid  out  1  data_out/sprite_on valid for pixel strobed 3 Clk earlier
- anim_frame  out  2  currently latched frame number (debug/HUD)

Behaviour:
- Reset values:
  - rom_addr=0, data_out=0, sprite_on=0, out_valid=0, anim_frame=0.
  - Latched X/Y=10'h3FF, so no pixel can hit.
  - Latched facing=0; walk phase=1; divider=0.
- Frame latch, on frame_start:
  - Capture MarioX, MarioY, facing_left, and the selected frame.
  - Frame selection: jumping -> NUM_FRAMES-1; else walking -> walk phase; else 0.
  - Input changes between frame_start pulses are ignored.
- Animation, evaluated on frame_start:
  - If walking and not jumping: divider increments. At ANIM_DIV-1 it wraps to 0 and the walk phase advances 1 -> 2 -> ... -> NUM_FRAMES-2 -> 1.
  - If not walking: divider=0 and phase=1, so each walk always starts on frame 1.
  - The latched frame uses the phase value before that edge's update.
- Hit test (stage 0):
  - hit = pix_en && DrawX >= X && DrawX < X+SPR_W && DrawY >= Y && DrawY < Y+SPR_H.
  - Sums are computed in 11 bits, so there is no wrap; sprites at the right/bottom edge are clipped, never wrapped to the left/top.
- Address:
  - col = DrawX-X (lower clog2(SPR_W) bits); mirrored to SPR_W-1-col when facing=1.
  - row = DrawY-Y.
  - rom_addr = frame*SPR_W*SPR_H + row*SPR_W + col, registered at stage 1.
  - When there is no hit, rom_addr holds its previous value.
- Pipeline:
  - pix_en and hit are delayed alongside the address.
  - Stage 2: rom_data arrives.
  - Stage 3 output register:
    - out_valid = pix_en delayed 3.
    - data_out = rom_data if hit_d else 0.
    - sprite_on = hit_d && rom_data != TRANSP_IDX.
  - Fixed latency 3 Clk, fully pipelined; one pixel per Clk is accepted.
- Output hold: when out_valid=0 the outputs hold their values, except sprite_on, which is forced to 0.
- Simultaneous frame_start and pix_en: the pixel uses the old latched state; new state applies from the next cycle.
- Reset mid-frame: pipeline is flushed (no out_valid for in-flight pixels); the sprite stays hidden until the next frame_start.

Decomposition:
- Package mario_sprite_pkg holds:
  - SPR_W, SPR_H, NUM_FRAMES, TRANSP_IDX, frame enum (FR_IDLE, FR_WALK1, FR_WALK2, FR_JUMP).
  - ADDR_W function.
  - These are shared with colorpalette and the ROM init script.
- One sub-module, mario_anim_ctrl, holds the divider, walk phase and frame selection.

Test Plan:
- Reset, then frame_start with MarioX=100, MarioY=200, idle; strobe (100,200):
  - 3 Clk later out_valid=1 and rom_addr=0 was issued.
  - With rom_data=4'h4: sprite_on=1, data_out=4'h4.
- Same setup, strobe (116,200) and (99,200):
  - out_valid=1, sprite_on=0, data_out=0 for both.
- facing_left=1, strobe (100,203): rom_addr=3*16+15=63.
- walking=1 held over 13 frame_starts, ANIM_DIV=6:
  - anim_frame sequence is 1 for 6 frames, then 2 for 6 frames, then 1.
  - With jumping=1, the next frame_start gives anim_frame=3.
- Transparency: rom_data=4'hA inside the box -> sprite_on=0, data_out=4'hA.
- Edge and timing cases:
  - MarioX=630: strobe (639,y) hits; strobe (0,y) does not.
  - frame_start coincident with pix_en uses old position.
  - Reset asserted with 2 pixels in flight -> no out_valid pulses.
